// File: rtl/seq_packer.sv
// rtl/seq_packer.sv - packs 2-bit DNA bases into 3-bit slot SRAM words; optional overflow guard: SEQ_PACKER_OVF_EN
module seq_packer #(
    parameter int DNA_PER_WORD    = 8,
    parameter int SRAM_WORD_WIDTH = 3 * DNA_PER_WORD,
    parameter int SRAM_ADDR_BIT   = 10
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start_i,
    input  logic [1:0]                 base_i,
    input  logic                       base_valid_i,
    input  logic                       seg_end_i,
    input  logic                       seq_last_i,
    output logic                       ready_o,
    output logic                       wreq_o,
    input  logic                       wgrant_i,
    output logic [SRAM_ADDR_BIT-1:0]   waddr_o,
    output logic [SRAM_WORD_WIDTH-1:0] wdata_o,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       ovf_o
);

    localparam int SW = $clog2(DNA_PER_WORD);
    localparam logic [2:0] END_CODE = 3'b000;
    localparam logic [2:0] BRK_CODE = 3'b001;

    typedef enum logic [1:0] {S_IDLE, S_PACK, S_TERM, S_FLUSH} state_t;

    state_t                         state;
    // slot 0 lives in the top element so the word reads MSB-first
    logic [DNA_PER_WORD-1:0][2:0]   pack_word;
    logic [DNA_PER_WORD-1:0][2:0]   nxt_word;
    logic [DNA_PER_WORD-1:0][2:0]   hand_word;
    logic [SW-1:0]                  slot;
    logic [SW-1:0]                  nxt_slot;
    logic [SW-1:0]                  idx0;
    logic [SW-1:0]                  idx1;
    logic                           pack_full;
    logic                           pend_end;
    logic [SRAM_ADDR_BIT-1:0]       next_addr;
    logic                           accept;
    logic                           step_term;
    logic                           complete;
    logic                           has_end;
    logic                           defer;
    logic                           can_hand;
    logic                           handoff;
    logic                           drop;

    // a full word waiting for the write register blocks new bases
    assign ready_o   = (state == S_PACK) && !pack_full;
    assign accept    = base_valid_i && ready_o;
    assign step_term = (state == S_TERM) && !pack_full;
    assign can_hand  = !wreq_o || wgrant_i;
    assign handoff   = (pack_full || complete) && can_hand;
    assign hand_word = pack_full ? pack_word : nxt_word;
    assign idx0      = SW'(DNA_PER_WORD - 1) - slot;
    assign idx1      = idx0 - SW'(1);

`ifdef SEQ_PACKER_OVF_EN
    localparam logic [SRAM_ADDR_BIT-1:0] ADDR_MAX = '1;
    logic top_used;
    logic ovf_q;
    // the last address is usable once; anything after it is dropped
    assign drop  = ovf_q || ((next_addr == ADDR_MAX) && top_used);
    assign ovf_o = ovf_q;
`else
    assign drop  = 1'b0;
    assign ovf_o = 1'b0;
`endif

    // next contents of the word under construction for this cycle
    always_comb begin
        nxt_word = pack_word;
        nxt_slot = slot;
        complete = 1'b0;
        has_end  = 1'b0;
        defer    = 1'b0;
        if (accept) begin
            nxt_word[idx0] = {1'b1, base_i};
            if (slot == SW'(DNA_PER_WORD - 1)) begin
                complete = 1'b1;
                defer    = seq_last_i || seg_end_i;
            end else if (seq_last_i) begin
                nxt_word[idx1] = END_CODE;
                complete       = 1'b1;
                has_end        = 1'b1;
            end else if (seg_end_i) begin
                nxt_word[idx1] = BRK_CODE;
                if (slot == SW'(DNA_PER_WORD - 2)) begin
                    complete = 1'b1;
                end else begin
                    nxt_slot = slot + SW'(2);
                end
            end else begin
                nxt_slot = slot + SW'(1);
            end
        end else if (step_term) begin
            nxt_word                 = '0;
            nxt_word[DNA_PER_WORD-1] = pend_end ? END_CODE : BRK_CODE;
            if (pend_end) begin
                complete = 1'b1;
                has_end  = 1'b1;
            end else begin
                nxt_slot = SW'(1);
            end
        end
    end

    // control FSM, pack register, write register and address counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            pack_word <= '0;
            slot      <= '0;
            pack_full <= 1'b0;
            pend_end  <= 1'b0;
            next_addr <= '0;
            wreq_o    <= 1'b0;
            waddr_o   <= '0;
            wdata_o   <= '0;
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
`ifdef SEQ_PACKER_OVF_EN
            top_used  <= 1'b0;
            ovf_q     <= 1'b0;
`endif
        end else begin
            done_o <= 1'b0;

            if (handoff) begin
                wdata_o <= hand_word;
                waddr_o <= next_addr;
                wreq_o  <= !drop;
`ifdef SEQ_PACKER_OVF_EN
                if (drop) begin
                    ovf_q <= 1'b1;
                end else if (next_addr == ADDR_MAX) begin
                    top_used <= 1'b1;
                end else begin
                    next_addr <= next_addr + 1'b1;
                end
`else
                next_addr <= next_addr + 1'b1;
`endif
            end else if (wreq_o && wgrant_i) begin
                wreq_o <= 1'b0;
            end

            if (handoff) begin
                pack_word <= '0;
                slot      <= '0;
                pack_full <= 1'b0;
            end else if (complete) begin
                pack_word <= nxt_word;
                pack_full <= 1'b1;
            end else if (accept || step_term) begin
                pack_word <= nxt_word;
                slot      <= nxt_slot;
            end

            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        state     <= S_PACK;
                        busy_o    <= 1'b1;
                        pack_word <= '0;
                        slot      <= '0;
                        pack_full <= 1'b0;
                        next_addr <= '0;
`ifdef SEQ_PACKER_OVF_EN
                        top_used  <= 1'b0;
                        ovf_q     <= 1'b0;
`endif
                    end
                end
                S_PACK, S_TERM: begin
                    if (complete) begin
                        if (has_end) begin
                            state <= S_FLUSH;
                        end else if (defer) begin
                            state    <= S_TERM;
                            pend_end <= seq_last_i;
                        end else begin
                            state <= S_PACK;
                        end
                    end else if (step_term) begin
                        state <= S_PACK;
                    end
                end
                S_FLUSH: begin
                    if (!pack_full && can_hand) begin
                        done_o <= 1'b1;
                        busy_o <= 1'b0;
                        state  <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_packer.sv
// tb/tb_seq_packer.sv - randomized self-checking bench for seq_packer against a flat slot-list model
module tb_seq_packer;

    localparam int AB = 2;
    localparam int NA = 1 << AB;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start_i = 1'b0;
    logic [1:0]    base_i = 2'b00;
    logic          base_valid_i = 1'b0;
    logic          seg_end_i = 1'b0;
    logic          seq_last_i = 1'b0;
    logic          ready_o;
    logic          wreq_o;
    logic          wgrant_i = 1'b0;
    logic [AB-1:0] waddr_o;
    logic [23:0]   wdata_o;
    logic          busy_o;
    logic          done_o;
    logic          ovf_o;

    int n_assert = 0;
    int n_fail = 0;
    int gnt_pct = 100;
    bit gnt_en = 1'b1;
    int stall_cnt = 0;

    logic [1:0]    seq_b[$];
    bit            seq_s[$];
    bit            seq_l[$];
    logic [AB-1:0] wr_addr[$];
    logic [23:0]   wr_data[$];

    seq_packer #(.SRAM_ADDR_BIT(AB)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .base_i(base_i),
        .base_valid_i(base_valid_i), .seg_end_i(seg_end_i), .seq_last_i(seq_last_i),
        .ready_o(ready_o), .wreq_o(wreq_o), .wgrant_i(wgrant_i), .waddr_o(waddr_o),
        .wdata_o(wdata_o), .busy_o(busy_o), .done_o(done_o), .ovf_o(ovf_o)
    );

    always #5 clk = ~clk;

    // grant decided mid-cycle; every granted word is logged as an SRAM write
    always @(negedge clk) begin
        if (rst_n && wreq_o && gnt_en && ($urandom_range(99) < gnt_pct)) begin
            wgrant_i = 1'b1;
            wr_addr.push_back(waddr_o);
            wr_data.push_back(wdata_o);
        end else begin
            wgrant_i = 1'b0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_seq();
        seq_b.delete();
        seq_s.delete();
        seq_l.delete();
    endtask

    task automatic push_item(input logic [1:0] b, input bit s, input bit l);
        seq_b.push_back(b);
        seq_s.push_back(s);
        seq_l.push_back(l);
    endtask

    task automatic make_rand(input int len, input int seg_pct);
        clear_seq();
        for (int i = 0; i < len; i++)
            push_item(2'($urandom_range(3)), ($urandom_range(99) < seg_pct), (i == len - 1));
    endtask

    task automatic start_seq(input string tag);
        @(negedge clk);
        wr_addr.delete();
        wr_data.delete();
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        check({tag, "_busy"}, busy_o, 1);
        check({tag, "_ovf_clr"}, ovf_o, 0);
    endtask

    task automatic send_base(input logic [1:0] b, input bit s, input bit l);
        int n = 0;
        base_i = b;
        seg_end_i = s;
        seq_last_i = l;
        base_valid_i = 1'b1;
        while (!ready_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n > 0) stall_cnt++;
        check("accept_timeout", (n < 200), 1);
        @(negedge clk);
        base_valid_i = 1'b0;
        seg_end_i = 1'b0;
        seq_last_i = 1'b0;
    endtask

    task automatic send_all(input int gap_pct);
        for (int i = 0; i < seq_b.size(); i++) begin
            send_base(seq_b[i], seq_s[i], seq_l[i]);
            if (i != seq_b.size() - 1 && $urandom_range(99) < gap_pct)
                repeat ($urandom_range(3)) @(negedge clk);
        end
    endtask

    task automatic finish_check(input string tag);
        int n = 0;
        bit seen = 1'b0;
        logic [2:0] codes[$];
        logic [23:0] words[$];
        logic [23:0] w;
        int n_wr;
        int n_cmp;
        bit ovf_exp;
        while (n < 400 && !seen) begin
            if (done_o) seen = 1'b1;
            else begin
                @(negedge clk);
                n++;
            end
        end
        check({tag, "_done"}, seen, 1);
        @(negedge clk);
        check({tag, "_done_pulse"}, done_o, 0);
        check({tag, "_idle_busy"}, busy_o, 0);

        // model: the stream is a flat list of slot codes chopped into 8-slot words
        for (int i = 0; i < seq_b.size(); i++) begin
            codes.push_back({1'b1, seq_b[i]});
            if (seq_l[i]) begin
                codes.push_back(3'b000);
                break;
            end
            if (seq_s[i]) codes.push_back(3'b001);
        end
        while (codes.size() % 8 != 0) codes.push_back(3'b000);
        for (int j = 0; j < codes.size() / 8; j++) begin
            w = '0;
            for (int k = 0; k < 8; k++) w = {w[20:0], codes[8 * j + k]};
            words.push_back(w);
        end
`ifdef SEQ_PACKER_OVF_EN
        n_wr = (words.size() > NA) ? NA : words.size();
        ovf_exp = (words.size() > NA);
`else
        n_wr = words.size();
        ovf_exp = 1'b0;
`endif
        check({tag, "_nwrites"}, wr_data.size(), n_wr);
        check({tag, "_ovf"}, ovf_o, ovf_exp);
        n_cmp = (wr_data.size() < n_wr) ? wr_data.size() : n_wr;
        for (int j = 0; j < n_cmp; j++) begin
            check($sformatf("%s_addr%0d", tag, j), wr_addr[j], j % NA);
            check($sformatf("%s_data%0d", tag, j), wr_data[j], words[j]);
        end
    endtask

    initial begin
        // reset state
        #12;
        check("rst_ready", ready_o, 0);
        check("rst_wreq", wreq_o, 0);
        check("rst_waddr", waddr_o, 0);
        check("rst_wdata", wdata_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        check("rst_ovf", ovf_o, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // one full word then END deferred into its own word
        clear_seq();
        for (int i = 0; i < 8; i++) push_item(2'(i % 4), 1'b0, (i == 7));
        gnt_pct = 100;
        start_seq("acgt");
        send_all(0);
        check("acgt_term_bubble", ready_o, 0);
        finish_check("acgt");

        // short sequence: END mid-word, ready drops right after acceptance
        clear_seq();
        for (int i = 0; i < 3; i++) push_item(2'b00, 1'b0, (i == 2));
        start_seq("aaa");
        send_all(0);
        check("aaa_ready_low", ready_o, 0);
        finish_check("aaa");

        // segment break then END in one word
        clear_seq();
        push_item(2'b00, 1'b1, 1'b0);
        push_item(2'b01, 1'b0, 1'b1);
        start_seq("brk");
        send_all(0);
        finish_check("brk");

        // 24 back-to-back bases with the first grant held off 10 cycles
        make_rand(24, 0);
        gnt_en = 1'b0;
        stall_cnt = 0;
        start_seq("stall");
        fork
            send_all(0);
            begin
                int n = 0;
                while (!wreq_o && n < 100) begin
                    @(negedge clk);
                    n++;
                end
                check("stall_wreq_seen", wreq_o, 1);
                repeat (10) @(negedge clk);
                gnt_en = 1'b1;
            end
        join
        check("stall_ready_dropped", (stall_cnt > 0), 1);
        finish_check("stall");

        // five full words: overflow or address wrap depending on build
        make_rand(39, 0);
        for (int i = 0; i < 39; i++) seq_s[i] = 1'b0;
        start_seq("wrap");
        send_all(0);
        finish_check("wrap");

        // random sequences, random gaps, random grant delay
        gnt_pct = 60;
        for (int r = 0; r < 8; r++) begin
            make_rand($urandom_range(1, 40), 15);
            start_seq($sformatf("rnd%0d", r));
            send_all(30);
            finish_check($sformatf("rnd%0d", r));
        end

        // asynchronous reset while a write is pending
        gnt_pct = 100;
        gnt_en = 1'b0;
        make_rand(9, 0);
        start_seq("rst");
        for (int i = 0; i < 8; i++) send_base(seq_b[i], 1'b0, 1'b0);
        check("rst_mid_wreq_before", wreq_o, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_wreq", wreq_o, 0);
        check("rst_mid_busy", busy_o, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        gnt_en = 1'b1;
        clear_seq();
        for (int i = 0; i < 3; i++) push_item(2'b00, 1'b0, (i == 2));
        start_seq("post_rst");
        send_all(0);
        finish_check("post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
